// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
//  Module   : button_events
//  Purpose  : Gesture decoder for a debounced, active-low push button.
//             Produces one-cycle strobes for press, release, short click,
//             double click, long press and auto-repeat, plus a held level.
//             The input is assumed glitch-free and synchronous to clk.
//  Ports    : clk        - pixel clock, rising edge
//             rst_n      - asynchronous active-low reset
//             btn_n      - debounced button level, active-low
//             press_p    - strobe, button went down
//             release_p  - strobe, button went up
//             click_p    - strobe, release of a short (pre-long) press
//             dbl_p      - strobe, press inside the window after a click
//             long_p     - strobe, hold reached LONG_CNT cycles
//             rpt_p      - strobe, every REPEAT_CNT cycles after long_p
//             held       - level, button considered pressed
//  Revision : 1.0  initial release
// ============================================================================
module button_events #(
  parameter int unsigned LONG_CNT   = 12_500_000,
  parameter int unsigned REPEAT_CNT = 2_500_000,
  parameter int unsigned DCLICK_WIN = 7_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic dbl_p,
  output logic long_p,
  output logic rpt_p,
  output logic held
);

  localparam int unsigned MAX_A = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
  localparam int unsigned MAX_P = (MAX_A > DCLICK_WIN) ? MAX_A : DCLICK_WIN;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CNT - 1);
  localparam logic [CW-1:0] GAP_WIN   = CW'(DCLICK_WIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_LONG = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          btn_q;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic          dbl_flag_q, dbl_flag_d;

  logic press_q, press_d;
  logic release_q, release_d;
  logic click_q, click_d;
  logic dbl_q, dbl_d;
  logic long_q, long_d;
  logic rpt_q, rpt_d;
  logic held_q, held_d;

  logic          w_press;
  logic          w_release;
  logic [CW-1:0] w_gap_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_press   = btn_q & ~btn_n;
  assign w_release = ~btn_q & btn_n;
  assign w_gap_inc = sat_inc(gap_cnt_q);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    dbl_flag_d = dbl_flag_q;
    press_d    = w_press;
    release_d  = w_release;
    click_d    = 1'b0;
    dbl_d      = 1'b0;
    long_d     = 1'b0;
    rpt_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_press) begin
          state_d    = ST_DOWN;
          hold_cnt_d = '0;
          dbl_flag_d = 1'b0;
        end
      end

      ST_DOWN: begin
        // Release is checked first so it wins over a coincident long_p.
        if (w_release) begin
          click_d = 1'b1;
          if (dbl_flag_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end else if (hold_cnt_q == LONG_LAST) begin
          long_d    = 1'b1;
          state_d   = ST_LONG;
          rpt_cnt_d = '0;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end

      ST_LONG: begin
        if (w_release) begin
          state_d = ST_IDLE;
        end else if (rpt_cnt_q == RPT_LAST) begin
          rpt_d     = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = sat_inc(rpt_cnt_q);
        end
      end

      ST_GAP: begin
        gap_cnt_d = w_gap_inc;
        // A press on the edge where the window closes is an ordinary press.
        if (w_press) begin
          state_d    = ST_DOWN;
          hold_cnt_d = '0;
          dbl_d      = (w_gap_inc < GAP_WIN);
          dbl_flag_d = (w_gap_inc < GAP_WIN);
        end else if (w_gap_inc >= GAP_WIN) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    held_d = (state_d == ST_DOWN) || (state_d == ST_LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      btn_q      <= 1'b1;
      hold_cnt_q <= '0;
      rpt_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      dbl_flag_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      click_q    <= 1'b0;
      dbl_q      <= 1'b0;
      long_q     <= 1'b0;
      rpt_q      <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_n;
      hold_cnt_q <= hold_cnt_d;
      rpt_cnt_q  <= rpt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      dbl_flag_q <= dbl_flag_d;
      press_q    <= press_d;
      release_q  <= release_d;
      click_q    <= click_d;
      dbl_q      <= dbl_d;
      long_q     <= long_d;
      rpt_q      <= rpt_d;
      held_q     <= held_d;
    end
  end

  assign press_p   = press_q;
  assign release_p = release_q;
  assign click_p   = click_q;
  assign dbl_p     = dbl_q;
  assign long_p    = long_q;
  assign rpt_p     = rpt_q;
  assign held      = held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_events
//  Purpose  : Self-checking bench for button_events. A segment table with
//             hand-derived strobe expectations, a reset sequence, and a
//             random btn_n stream, all cross-checked every cycle against a
//             time-based reference model through an expectation queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_events;

  localparam int LONG_CNT   = 20;
  localparam int REPEAT_CNT = 5;
  localparam int DCLICK_WIN = 10;

  localparam logic [5:0] S_P = 6'b100000;
  localparam logic [5:0] S_R = 6'b010000;
  localparam logic [5:0] S_C = 6'b001000;
  localparam logic [5:0] S_D = 6'b000100;
  localparam int         NSEG = 27;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic press_p, release_p, click_p, dbl_p, long_p, rpt_p, held;
  logic [6:0] obs;

  assign obs = {press_p, release_p, click_p, dbl_p, long_p, rpt_p, held};

  always #5 clk = ~clk;

  button_events #(
    .LONG_CNT  (LONG_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .DCLICK_WIN(DCLICK_WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (btn_n),
    .press_p  (press_p),
    .release_p(release_p),
    .click_p  (click_p),
    .dbl_p    (dbl_p),
    .long_p   (long_p),
    .rpt_p    (rpt_p),
    .held     (held)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [6:0] sb_q[$];
  logic [5:0] prev_strb = '0;

  // Reference model: tracks edge counts since press / since click release.
  logic m_prev;
  int   m_hold;
  bit   m_long_done;
  bit   m_win;
  int   m_since;
  bit   m_second;

  task automatic model_reset();
    m_prev = 1'b1; m_hold = 0; m_long_done = 0;
    m_win = 0; m_since = 0; m_second = 0;
  endtask

  task automatic model_step(input logic b, output logic [6:0] e);
    logic pr, rl, ck, db, lg, rp;
    pr = m_prev & ~b;
    rl = ~m_prev & b;
    ck = 0; db = 0; lg = 0; rp = 0;
    if (m_win) begin
      m_since++;
      if (pr) begin
        db    = (m_since < DCLICK_WIN);
        m_win = 0;
      end else if (m_since >= DCLICK_WIN) begin
        m_win = 0;
      end
    end
    if (pr) begin
      m_hold = 0; m_long_done = 0; m_second = db;
    end else if (!b) begin
      m_hold++;
      if (!m_long_done && m_hold == LONG_CNT) begin
        lg = 1; m_long_done = 1;
      end else if (m_long_done && m_hold > LONG_CNT &&
                   ((m_hold - LONG_CNT) % REPEAT_CNT) == 0) begin
        rp = 1;
      end
    end
    if (rl) begin
      ck = !m_long_done;
      if (ck && !m_second) begin
        m_win = 1; m_since = 0;
      end
    end
    m_prev = b;
    e = {pr, rl, ck, db, lg, rp, ~b};
  endtask

  task automatic sb_check();
    logic [6:0] e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty cyc=%0d got=%b", cyc, obs);
    end else begin
      e = sb_q.pop_front();
      if (obs !== e) begin
        n_err++;
        $display("FAIL sb cyc=%0d got=%b exp=%b (press,rel,click,dbl,long,rpt,held)",
                 cyc, obs, e);
      end
    end
    n_vec++;
    if (|(prev_strb & obs[6:1])) begin
      n_err++;
      $display("FAIL strobe_width cyc=%0d got=%b prev=%b exp no overlap", cyc, obs[6:1], prev_strb);
    end
    prev_strb = obs[6:1];
  endtask

  task automatic step(input logic b);
    logic [6:0] e;
    btn_n = b;
    model_step(b, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    sb_check();
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (obs !== 7'b0) begin
      n_err++;
      $display("FAIL %s got=%b exp=0000000", name, obs);
    end
  endtask

  typedef struct {
    logic       btn;
    int         n;
    logic [5:0] first;     // {press,rel,click,dbl,long,rpt} after first edge
    int         long_idx;  // segment index of long_p, -1 if none
    int         n_rpt;
  } seg_t;

  seg_t tbl[NSEG];

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         long_seen;
    int         rpt_n;
    logic       lvl;
    int         run;

    tbl[0]  = '{1'b1, 15, 6'b0,      -1, 0};
    tbl[1]  = '{1'b0,  8, S_P,       -1, 0};  // short press
    tbl[2]  = '{1'b1, 15, S_R | S_C, -1, 0};
    tbl[3]  = '{1'b0, 41, S_P,       20, 4};  // long hold with repeats
    tbl[4]  = '{1'b1, 12, S_R,       -1, 0};
    tbl[5]  = '{1'b0, 20, S_P,       -1, 0};  // release on the long edge
    tbl[6]  = '{1'b1, 12, S_R | S_C, -1, 0};
    tbl[7]  = '{1'b0, 21, S_P,       20, 0};  // one cycle longer
    tbl[8]  = '{1'b1, 12, S_R,       -1, 0};
    tbl[9]  = '{1'b0,  5, S_P,       -1, 0};  // double click, gap 6
    tbl[10] = '{1'b1,  6, S_R | S_C, -1, 0};
    tbl[11] = '{1'b0,  5, S_P | S_D, -1, 0};
    tbl[12] = '{1'b1,  4, S_R | S_C, -1, 0};
    tbl[13] = '{1'b0,  5, S_P,       -1, 0};  // third press, no dbl
    tbl[14] = '{1'b1, 12, S_R | S_C, -1, 0};
    tbl[15] = '{1'b0,  5, S_P,       -1, 0};  // gap of 10: no dbl
    tbl[16] = '{1'b1, 10, S_R | S_C, -1, 0};
    tbl[17] = '{1'b0,  5, S_P,       -1, 0};
    tbl[18] = '{1'b1, 12, S_R | S_C, -1, 0};
    tbl[19] = '{1'b0,  5, S_P,       -1, 0};  // gap of 9: dbl
    tbl[20] = '{1'b1,  9, S_R | S_C, -1, 0};
    tbl[21] = '{1'b0,  5, S_P | S_D, -1, 0};
    tbl[22] = '{1'b1, 12, S_R | S_C, -1, 0};
    tbl[23] = '{1'b0,  3, S_P,       -1, 0};  // second press goes long
    tbl[24] = '{1'b1,  3, S_R | S_C, -1, 0};
    tbl[25] = '{1'b0, 27, S_P | S_D, 20, 1};
    tbl[26] = '{1'b1, 12, S_R,       -1, 0};

    // Reset with button released.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_idle");
    rst_n = 1'b1;

    for (int s = 0; s < NSEG; s++) begin
      long_seen = -1;
      rpt_n     = 0;
      for (int i = 0; i < tbl[s].n; i++) begin
        step(tbl[s].btn);
        if (i == 0) begin
          n_vec++;
          if (obs[6:1] !== tbl[s].first) begin
            n_err++;
            $display("FAIL seg%0d_first got=%b exp=%b", s, obs[6:1], tbl[s].first);
          end
        end
        if (long_p && long_seen < 0) long_seen = i;
        if (rpt_p) rpt_n++;
      end
      n_vec++;
      if (long_seen != tbl[s].long_idx) begin
        n_err++;
        $display("FAIL seg%0d_long_idx got=%0d exp=%0d", s, long_seen, tbl[s].long_idx);
      end
      n_vec++;
      if (rpt_n != tbl[s].n_rpt) begin
        n_err++;
        $display("FAIL seg%0d_rpt_count got=%0d exp=%0d", s, rpt_n, tbl[s].n_rpt);
      end
    end

    // Asynchronous reset in the middle of a hold, button kept low.
    repeat (12) step(1'b0);
    n_vec++;
    if (held !== 1'b1) begin
      n_err++;
      $display("FAIL hold_before_reset got=%b exp=1", held);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    sb_q.delete();
    prev_strb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_btn_low");
    rst_n = 1'b1;
    step(1'b0);
    n_vec++;
    if (press_p !== 1'b1) begin
      n_err++;
      $display("FAIL press_after_reset got=%b exp=1", press_p);
    end
    repeat (4) step(1'b0);
    repeat (15) step(1'b1);

    // Random stream of runs.
    lvl = 1'b1;
    while (cyc < 10500) begin
      lvl = ~lvl;
      run = $urandom_range(50, 1);
      repeat (run) step(lvl);
    end
    repeat (15) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
